// File: rtl/conv_pkg.sv
// Shared definitions for the CONV layer-memory arbiter: bus widths,
// memory-select encodings, arbiter state codes and a small select helper.
package conv_pkg;

  // Address {y[5:0],x[5:0]}, 4.16 fixed-point data, memory select width
  localparam int CONV_AW = 12;
  localparam int CONV_DW = 20;
  localparam int CONV_SW = 3;

  // Target memory select encodings
  localparam logic [CONV_SW-1:0] CSEL_NONE  = 3'd0;
  localparam logic [CONV_SW-1:0] CSEL_L0_K0 = 3'd1;
  localparam logic [CONV_SW-1:0] CSEL_L0_K1 = 3'd2;
  localparam logic [CONV_SW-1:0] CSEL_L1_K0 = 3'd3;
  localparam logic [CONV_SW-1:0] CSEL_L1_K1 = 3'd4;
  localparam logic [CONV_SW-1:0] CSEL_L2    = 3'd5;

  // Arbiter states: ARB = no owner, LOCK = ownership pinned to lock_id
  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // A command with select NONE is accepted but must not strobe the memory
  function automatic logic sel_issues_strobe(input logic [CONV_SW-1:0] sel);
    return (sel != CSEL_NONE);
  endfunction

endpackage

// File: rtl/conv_rr_pick.sv
// Two-input round-robin picker. Requests are first filtered by an
// eligibility mask (used to pin ownership while locked); on a tie the
// pointer selects the winner (0 -> master 0, 1 -> master 1).
module conv_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] elig_s;

  // Mask the requests, then grant a single eligible requester (one-hot)
  always_comb begin
    elig_s = req & mask;
    case (elig_s)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/conv_mem_arbiter.sv
// Layer-memory port arbiter between the conv engine (master 0) and the
// pool/flatten engine (master 1). Grants are combinational; the granted
// command is registered onto the memory port one cycle later, and read
// data returns registered one cycle after the strobe. A master can lock
// ownership across several beats (e.g. a 2x2 max-pool window).
module conv_mem_arbiter
  import conv_pkg::*;
#(
  parameter int AW = CONV_AW,
  parameter int DW = CONV_DW,
  parameter int SW = CONV_SW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [SW-1:0] m0_sel,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [SW-1:0] m1_sel,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          crd,
  output logic          cwr,
  output logic [SW-1:0] csel,
  output logic [AW-1:0] caddr_rd,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  input  logic [DW-1:0] cdata_rd,
  output logic [1:0]    owner
);

  // Arbitration / lock FSM state
  logic [0:0]    state_q, state_d;
  logic          lock_id_q, lock_id_d;
  logic          rr_ptr_q, rr_ptr_d;

  // Command register stage (drives the memory port)
  logic          crd_q, crd_d;
  logic          cwr_q, cwr_d;
  logic [SW-1:0] csel_q, csel_d;
  logic [AW-1:0] caddr_rd_q, caddr_rd_d;
  logic [AW-1:0] caddr_wr_q, caddr_wr_d;
  logic [DW-1:0] cdata_wr_q, cdata_wr_d;

  // Read-return stage
  logic          rd_pend_q, rd_pend_d;
  logic          rd_id_q, rd_id_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rvalid_q, rvalid_d;

  // Grant and selected-command signals
  logic [1:0]    mask_s;
  logic [1:0]    pick_gnt_s;
  logic [1:0]    gnt_s;
  logic          any_gnt_s;
  logic          win_s;
  logic          c_we_s;
  logic          c_lock_s;
  logic [SW-1:0] c_sel_s;
  logic [AW-1:0] c_addr_s;
  logic [DW-1:0] c_wdata_s;

  // While locked only the owner is eligible; otherwise both masters are
  always_comb begin
    if (state_q == ST_LOCK) begin
      mask_s = lock_id_q ? 2'b10 : 2'b01;
    end else begin
      mask_s = 2'b11;
    end
  end

  conv_rr_pick u_pick (
    .req  ({m1_req, m0_req}),
    .ptr  (rr_ptr_q),
    .mask (mask_s),
    .gnt  (pick_gnt_s)
  );

  // Suppress grants while reset is asserted so no command is accepted
  always_comb begin
    gnt_s     = pick_gnt_s & {2{reset_n}};
    any_gnt_s = |gnt_s;
    win_s     = gnt_s[1];
  end

  // Route the winning master's command fields to the register stage
  always_comb begin
    if (win_s) begin
      c_we_s    = m1_we;
      c_lock_s  = m1_lock;
      c_sel_s   = m1_sel;
      c_addr_s  = m1_addr;
      c_wdata_s = m1_wdata;
    end else begin
      c_we_s    = m0_we;
      c_lock_s  = m0_lock;
      c_sel_s   = m0_sel;
      c_addr_s  = m0_addr;
      c_wdata_s = m0_wdata;
    end
  end

  // Lock FSM and round-robin pointer: the pointer always favours the
  // loser of the latest grant; a locked grant pins ownership until the
  // owner issues a beat with lock=0 (no timeout if the owner goes idle)
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (any_gnt_s) begin
      rr_ptr_d = ~win_s;
      case (state_q)
        ST_ARB: begin
          if (c_lock_s) begin
            state_d   = ST_LOCK;
            lock_id_d = win_s;
          end else begin
            state_d   = ST_ARB;
          end
        end
        ST_LOCK: begin
          if (c_lock_s) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_ARB;
          end
        end
        default: begin
          state_d = ST_ARB;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Command stage: strobes/select pulse for one cycle per accepted command;
  // addresses and write data hold their last value between commands
  always_comb begin
    crd_d      = 1'b0;
    cwr_d      = 1'b0;
    csel_d     = {SW{1'b0}};
    caddr_rd_d = caddr_rd_q;
    caddr_wr_d = caddr_wr_q;
    cdata_wr_d = cdata_wr_q;
    rd_pend_d  = 1'b0;
    rd_id_d    = rd_id_q;
    if (any_gnt_s) begin
      csel_d = c_sel_s;
      if (c_we_s) begin
        cwr_d      = sel_issues_strobe(c_sel_s);
        caddr_wr_d = c_addr_s;
        cdata_wr_d = c_wdata_s;
      end else begin
        crd_d      = sel_issues_strobe(c_sel_s);
        caddr_rd_d = c_addr_s;
        rd_pend_d  = 1'b1;
        rd_id_d    = win_s;
      end
    end else begin
      crd_d = 1'b0;
      cwr_d = 1'b0;
    end
  end

  // Read return: capture memory data during the strobe cycle; a read to
  // select NONE still returns a response, with zero data
  always_comb begin
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    if (rd_pend_q) begin
      rvalid_d = rd_id_q ? 2'b10 : 2'b01;
      rdata_d  = crd_q ? cdata_rd : {DW{1'b0}};
    end else begin
      rvalid_d = 2'b00;
    end
  end

  // State and pipeline registers; reset discards any in-flight command
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ARB;
      lock_id_q  <= 1'b0;
      rr_ptr_q   <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= {SW{1'b0}};
      caddr_rd_q <= {AW{1'b0}};
      caddr_wr_q <= {AW{1'b0}};
      cdata_wr_q <= {DW{1'b0}};
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
      rdata_q    <= {DW{1'b0}};
      rvalid_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      lock_id_q  <= lock_id_d;
      rr_ptr_q   <= rr_ptr_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      csel_q     <= csel_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Output mapping; read data is a shared bus qualified by each rvalid
  always_comb begin
    m0_gnt    = gnt_s[0];
    m1_gnt    = gnt_s[1];
    m0_rvalid = rvalid_q[0];
    m1_rvalid = rvalid_q[1];
    m0_rdata  = rdata_q;
    m1_rdata  = rdata_q;
    crd       = crd_q;
    cwr       = cwr_q;
    csel      = csel_q;
    caddr_rd  = caddr_rd_q;
    caddr_wr  = caddr_wr_q;
    cdata_wr  = cdata_wr_q;
    owner     = {(state_q == ST_LOCK), (state_q == ST_LOCK) & lock_id_q};
  end

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Self-checking bench for conv_mem_arbiter: a transaction-level model
// (grant rules, return queue with due cycles, memory function) is compared
// against the DUT every falling edge, plus directed literal expectations.
module tb_conv_mem_arbiter;
  import conv_pkg::*;

  localparam int AW = CONV_AW;
  localparam int DW = CONV_DW;
  localparam int SW = CONV_SW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [SW-1:0] m0_sel, m1_sel;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          crd, cwr;
  logic [SW-1:0] csel;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_wr, cdata_rd;
  logic [1:0]    owner;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_sel(m0_sel),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_sel(m1_sel),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .crd(crd), .cwr(cwr), .csel(csel), .caddr_rd(caddr_rd),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .cdata_rd(cdata_rd),
    .owner(owner)
  );

  // Memory contents as a pure function of select and address
  function automatic logic [DW-1:0] mem_word(input logic [SW-1:0] s, input logic [AW-1:0] a);
    return {s, 5'd0, a};
  endfunction

  always_comb cdata_rd = mem_word(csel, caddr_rd);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          rq[$];
  bit            m_locked, m_id, m_ptr;
  int            cyc = 0;
  logic          e_crd, e_cwr;
  logic [SW-1:0] e_csel;
  logic [AW-1:0] e_ard, e_awr;
  logic [DW-1:0] e_wd;

  // Compare DUT against the model each falling edge, then advance the model
  always @(negedge clk) begin : cmp
    logic [1:0]    req_v, eg, erv;
    logic [DW-1:0] erd;
    bit            win, c_we, c_lock;
    logic [SW-1:0] c_sel;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    ret_t          r;
    cyc++;
    if (!reset_n) begin
      m_locked = 1'b0; m_id = 1'b0; m_ptr = 1'b0;
      rq.delete();
      e_crd = 1'b0; e_cwr = 1'b0; e_csel = '0; e_ard = '0; e_awr = '0; e_wd = '0;
      chk("rst_gnt", {m1_gnt, m0_gnt}, 32'd0);
      chk("rst_strobe", {crd, cwr}, 32'd0);
      chk("rst_csel", csel, 32'd0);
      chk("rst_caddr_rd", caddr_rd, 32'd0);
      chk("rst_caddr_wr", caddr_wr, 32'd0);
      chk("rst_cdata_wr", cdata_wr, 32'd0);
      chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 32'd0);
      chk("rst_rdata", {12'd0, m0_rdata | m1_rdata}, 32'd0);
      chk("rst_owner", owner, 32'd0);
    end else begin
      req_v = {m1_req, m0_req};
      eg = 2'b00;
      if (m_locked) begin
        if (req_v[m_id]) eg[m_id] = 1'b1;
      end else if (req_v == 2'b11) begin
        eg[m_ptr] = 1'b1;
      end else begin
        eg = req_v;
      end
      while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
      erv = 2'b00;
      erd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        erv[rq[0].id] = 1'b1;
        erd = rq[0].data;
        void'(rq.pop_front());
      end
      chk("gnt", {m1_gnt, m0_gnt}, eg);
      chk("crd", crd, e_crd);
      chk("cwr", cwr, e_cwr);
      chk("csel", csel, e_csel);
      chk("caddr_rd", caddr_rd, e_ard);
      chk("caddr_wr", caddr_wr, e_awr);
      chk("cdata_wr", cdata_wr, e_wd);
      chk("rvalid", {m1_rvalid, m0_rvalid}, erv);
      if (erv[0]) chk("m0_rdata", m0_rdata, erd);
      if (erv[1]) chk("m1_rdata", m1_rdata, erd);
      chk("owner", owner, {m_locked, m_locked & m_id});
      e_crd = 1'b0; e_cwr = 1'b0; e_csel = '0;
      if (eg != 2'b00) begin
        win     = eg[1];
        c_we    = win ? m1_we : m0_we;
        c_lock  = win ? m1_lock : m0_lock;
        c_sel   = win ? m1_sel : m0_sel;
        c_addr  = win ? m1_addr : m0_addr;
        c_wdata = win ? m1_wdata : m0_wdata;
        e_csel  = c_sel;
        if (c_we) begin
          e_cwr = (c_sel != CSEL_NONE);
          e_awr = c_addr;
          e_wd  = c_wdata;
        end else begin
          e_crd  = (c_sel != CSEL_NONE);
          e_ard  = c_addr;
          r.due  = cyc + 2;
          r.id   = win;
          r.data = (c_sel != CSEL_NONE) ? mem_word(c_sel, c_addr) : '0;
          rq.push_back(r);
        end
        m_ptr = ~win;
        if (!m_locked && c_lock) begin
          m_locked = 1'b1;
          m_id     = win;
        end else if (m_locked && !c_lock) begin
          m_locked = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] col_data[$];
  int            col_cyc[$];
  bit            col_en = 1'b0;
  int            col_n  = 0;

  // Collect master-1 read returns during the streaming test
  always @(negedge clk) begin
    if (col_en) begin
      col_n++;
      if (m1_rvalid) begin
        col_data.push_back(m1_rdata);
        col_cyc.push_back(col_n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic r, we, lk, input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_req = r; m0_we = we; m0_lock = lk; m0_sel = s; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drv1(input logic r, we, lk, input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_req = r; m1_we = we; m1_lock = lk; m1_sel = s; m1_addr = a; m1_wdata = d;
  endtask

  initial begin : stim
    logic [3:0]    g0, g1;
    logic [5:0]    rv0, rv1, m0g, m1g;
    logic [DW-1:0] rd2, rd3;
    logic [1:0]    own[6];
    logic [5:0]    ii;
    logic [AW-1:0] a;
    int            rvc;

    reset_n = 1'b0;
    drv0(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
    drv1(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_owner", owner, 32'd0);
    tick();
    reset_n = 1'b1;

    // Lone m0 write: granted at once, on the port next cycle
    drv0(1'b1, 1'b1, 1'b0, CSEL_L0_K0, 12'h041, 20'h01310);
    @(negedge clk);
    chk("t2_gnt", m0_gnt, 32'd1);
    tick();
    drv0(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
    @(negedge clk);
    chk("t2_cwr", cwr, 32'd1);
    chk("t2_csel", csel, 32'd1);
    chk("t2_caddr_wr", caddr_wr, 32'h041);
    chk("t2_cdata_wr", cdata_wr, 32'h01310);
    tick();

    // Lone m1 write so the round-robin pointer favours m0 again
    drv1(1'b1, 1'b1, 1'b0, CSEL_L1_K1, 12'h7ff, 20'h00077);
    tick();
    drv1(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
    tick();

    // Both masters read for 4 cycles: grants alternate, returns 2 cycles later
    drv0(1'b1, 1'b0, 1'b0, CSEL_L0_K0, 12'h010, 20'h00000);
    drv1(1'b1, 1'b0, 1'b0, CSEL_L1_K0, 12'h020, 20'h00000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin
        g0[k] = m0_gnt;
        g1[k] = m1_gnt;
      end
      rv0[k] = m0_rvalid;
      rv1[k] = m1_rvalid;
      if (k == 2) rd2 = m0_rdata;
      if (k == 3) rd3 = m1_rdata;
      tick();
      if (k == 3) begin
        drv0(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
        drv1(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
      end
    end
    chk("t3_m0_gnts", g0, 32'b0101);
    chk("t3_m1_gnts", g1, 32'b1010);
    chk("t3_m0_rvalid", rv0, 32'b010100);
    chk("t3_m1_rvalid", rv1, 32'b101000);
    chk("t3_m0_rdata", rd2, 32'h20010);
    chk("t3_m1_rdata", rd3, 32'h60020);

    // m1 locked pool window (4 reads + write) while m0 waits
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: drv1(1'b1, 1'b0, 1'b1, CSEL_L0_K0, 12'h000, 20'h00000);
        1: begin
          drv1(1'b1, 1'b0, 1'b1, CSEL_L0_K0, 12'h001, 20'h00000);
          drv0(1'b1, 1'b1, 1'b0, CSEL_L0_K1, 12'h123, 20'h55555);
        end
        2: drv1(1'b1, 1'b0, 1'b1, CSEL_L0_K0, 12'h040, 20'h00000);
        3: drv1(1'b1, 1'b0, 1'b1, CSEL_L0_K0, 12'h041, 20'h00000);
        4: drv1(1'b1, 1'b1, 1'b0, CSEL_L1_K0, 12'h000, 20'h0abcd);
        5: drv1(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
        default: drv0(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
      endcase
      if (k < 6) begin
        @(negedge clk);
        m0g[k] = m0_gnt;
        m1g[k] = m1_gnt;
        own[k] = owner;
      end
      tick();
    end
    chk("t4_m0_gnts", m0g, 32'b100000);
    chk("t4_m1_gnts", m1g, 32'b011111);
    chk("t4_owner_locked", own[3], 32'b11);
    chk("t4_owner_released", own[5], 32'b00);

    // m1 locks then goes idle: m0 must be starved until m1 releases
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: drv1(1'b1, 1'b0, 1'b1, CSEL_L1_K1, 12'h00a, 20'h00000);
        1: begin
          drv1(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
          drv0(1'b1, 1'b0, 1'b0, CSEL_L0_K0, 12'h111, 20'h00000);
        end
        4: drv1(1'b1, 1'b0, 1'b0, CSEL_L1_K1, 12'h00b, 20'h00000);
        5: drv1(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
        6: drv0(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
        default: ;
      endcase
      if (k < 6) begin
        @(negedge clk);
        m0g[k] = m0_gnt;
        m1g[k] = m1_gnt;
        own[k] = owner;
      end
      tick();
    end
    chk("t5_m0_gnts", m0g, 32'b100000);
    chk("t5_m1_gnts", m1g, 32'b010001);
    chk("t5_owner_k1", own[1], 32'b11);
    chk("t5_owner_k3", own[3], 32'b11);

    // Read to select NONE: no strobe, zero data returned
    drv0(1'b1, 1'b0, 1'b0, CSEL_NONE, 12'h3c3, 20'h00000);
    tick();
    drv0(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
    @(negedge clk);
    chk("sel0_crd", crd, 32'd0);
    tick();
    @(negedge clk);
    chk("sel0_rvalid", m0_rvalid, 32'd1);
    chk("sel0_rdata", m0_rdata, 32'd0);
    tick();

    // 64 back-to-back m1 reads
    col_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ii = 6'(i);
      drv1(1'b1, 1'b0, 1'b0, CSEL_L1_K0, {ii, ~ii}, 20'h00000);
      tick();
    end
    drv1(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
    repeat (3) tick();
    col_en = 1'b0;
    chk("t6_count", col_data.size(), 32'd64);
    for (int j = 0; j < col_data.size() && j < 64; j++) begin
      ii = 6'(j);
      a  = {ii, ~ii};
      chk("t6_rdata", col_data[j], {3'd3, 5'd0, a});
    end
    if (col_cyc.size() == 64) chk("t6_spacing", col_cyc[63] - col_cyc[0], 32'd63);

    // Reset with a read in flight: outputs clear, response dropped, m0 first
    drv0(1'b1, 1'b0, 1'b0, CSEL_L0_K1, 12'h0ff, 20'h00000);
    tick();
    drv0(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t1_crd", crd, 32'd0);
    chk("t1_csel", csel, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    rvc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m0_rvalid || m1_rvalid) rvc++;
      tick();
    end
    chk("t1_no_rvalid", rvc, 32'd0);
    drv0(1'b1, 1'b0, 1'b0, CSEL_L0_K0, 12'h005, 20'h00000);
    drv1(1'b1, 1'b0, 1'b0, CSEL_L0_K0, 12'h006, 20'h00000);
    @(negedge clk);
    chk("t1_tie_m0", {m1_gnt, m0_gnt}, 32'b01);
    tick();
    drv0(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
    drv1(1'b0, 1'b0, 1'b0, CSEL_NONE, 12'h000, 20'h00000);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
